// File: rtl/led_step_ctrl_pkg.sv
// Shared definitions for the LED step controller: direction encodings,
// field widths, key indices and the position update helper.
package led_step_ctrl_pkg;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DN       = 1'b1;
  localparam int   SPEED_W      = 2;
  localparam int   POS_W        = 3;
  localparam logic KEY_RELEASED = 1'b1;

  // Key lanes, one debouncer each
  localparam int NUM_KEYS = 3;
  localparam int KEY_SPD  = 0;
  localparam int KEY_DIR  = 1;
  localparam int KEY_PAU  = 2;

  // Next LED position; modular wrap in both directions
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input logic             d);
    return (d == DIR_DN) ? pos - 1'b1 : pos + 1'b1;
  endfunction

endpackage

// File: rtl/led_step_ctrl_key_debounce.sv
// One push-key lane: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced released->pressed transition.
module key_debounce
  import led_step_ctrl_pkg::*;
#(
  parameter int DEB_CYC = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int             CW      = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Stability counter: any agreement with the stable state restarts it
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = ~stable_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
    press_d = (stable_q == KEY_RELEASED) && (stable_d != KEY_RELEASED);
  end

  // Synchronizer, debounce state and registered press pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= KEY_RELEASED;
      sync2_q  <= KEY_RELEASED;
      stable_q <= KEY_RELEASED;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
  assign level = stable_q;

endmodule

// File: rtl/led_step_ctrl.sv
// Single-clock step controller for the LED flasher: debounced speed,
// direction and pause keys steer a period counter that advances the
// 3-bit decoder position sw with a one-cycle step pulse.
module led_step_ctrl
  import led_step_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STEP_CYC = 12000000,
  parameter int DEB_CYC  = 240000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_speed,
  input  logic               key_dir,
  input  logic               key_pause,
  output logic [POS_W-1:0]   sw,
  output logic               step,
  output logic [SPEED_W-1:0] speed,
  output logic               dir,
  output logic               running
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP_CYC);

  logic [NUM_KEYS-1:0] keys_n, press, level, ev;

  assign keys_n = {key_pause, key_dir, key_speed};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n[k]),
      .press (press[k]),
      .level (level[k])
    );
  end

  // The pulse is emitted while the debounced level already reads pressed;
  // tying the two keeps an event meaningful only for a held key.
  assign ev = press & ~level;

  logic [WIDTH-1:0]   tc_q, tc_d;
  logic [POS_W-1:0]   sw_q, sw_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               dir_q, dir_d;
  logic               running_q, running_d;
  logic               step_q, step_d;
  logic [WIDTH-1:0]   period;
  logic               term;

  assign period = STEP_W >> speed_q;
  assign term   = running_q && (tc_q == period - 1'b1);

  // Next-state: terminal count steps with the current dir unless this
  // same edge pauses; key events all land together and may restart tc.
  always_comb begin
    tc_d      = running_q ? tc_q + 1'b1 : '0;
    sw_d      = sw_q;
    speed_d   = speed_q;
    dir_d     = dir_q;
    running_d = running_q;
    step_d    = 1'b0;
    if (term) begin
      tc_d = '0;
      if (!ev[KEY_PAU]) begin
        step_d = 1'b1;
        sw_d   = pos_next(sw_q, dir_q);
      end
    end
    if (ev[KEY_SPD]) begin
      speed_d = speed_q + 1'b1;
      tc_d    = '0;
    end
    if (ev[KEY_DIR]) dir_d = ~dir_q;
    if (ev[KEY_PAU]) begin
      running_d = ~running_q;
      tc_d      = '0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q      <= '0;
      sw_q      <= '0;
      speed_q   <= '0;
      dir_q     <= DIR_UP;
      running_q <= 1'b1;
      step_q    <= 1'b0;
    end else begin
      tc_q      <= tc_d;
      sw_q      <= sw_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      step_q    <= step_d;
    end
  end

  assign sw      = sw_q;
  assign step    = step_q;
  assign speed   = speed_q;
  assign dir     = dir_q;
  assign running = running_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with STEP_CYC=16, DEB_CYC=4.
// A clean press driven at a falling edge takes effect on the 7th rising
// edge: 2 sync flops, 4 stable cycles, one registered pulse cycle.
module tb_led_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_speed, key_dir, key_pause;
  logic [2:0] sw;
  logic       step;
  logic [1:0] speed;
  logic       dir, running;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int PRESS_LAT = 7;

  led_step_ctrl #(.WIDTH(32), .STEP_CYC(16), .DEB_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_speed (key_speed),
    .key_dir   (key_dir),
    .key_pause (key_pause),
    .sw        (sw),
    .step      (step),
    .speed     (speed),
    .dir       (dir),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the next step pulse, -1 if none within 100
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (step) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_speed = v;
      1:       key_dir   = v;
      default: key_pause = v;
    endcase
  endtask

  // Hold key k down until speed/dir/running changes; lat = cycles taken
  task automatic press(input int k, output int lat);
    logic [3:0] snap;
    snap = {speed, dir, running};
    set_key(k, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ({speed, dir, running} != snap) begin
        lat = i;
        break;
      end
    end
    set_key(k, 1'b1);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b0; key_speed = 1'b1; key_dir = 1'b1; key_pause = 1'b1;
    tick(3);
    n_chk++;
    if ({sw, step, speed, dir, running} !== 8'b000_0_00_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got sw=%0d step=%0d speed=%0d dir=%0d run=%0d, want 0/0/0/0/1",
               sw, step, speed, dir, running);
    end
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wait_step(n);
      n_chk++;
      if (n !== 16 || sw !== 3'(i % 8)) begin
        n_fail++;
        $display("FAIL free_run_%0d: got gap=%0d sw=%0d, want gap=16 sw=%0d", i, n, sw, i % 8);
      end
    end
  endtask

  task automatic test_dir_bounce;
    int n;
    logic [2:0] s0;
    for (int i = 0; i < 10; i++) begin
      key_dir = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    tick(8);
    n_chk++;
    if (dir !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_bounce_ignored: got dir=%0d, want 0", dir);
    end
    key_dir = 1'b0; tick(10);
    key_dir = 1'b1; tick(10);
    n_chk++;
    if (dir !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_one_toggle: got dir=%0d, want 1", dir);
    end
    wait_step(n);
    s0 = sw;
    for (int i = 0; i < 8; i++) begin
      wait_step(n);
      n_chk++;
      if (n !== 16 || sw !== 3'(s0 - 3'(i + 1))) begin
        n_fail++;
        $display("FAIL count_down_%0d: got gap=%0d sw=%0d, want gap=16 sw=%0d",
                 i, n, sw, 3'(s0 - 3'(i + 1)));
      end
    end
  endtask

  task automatic test_speed;
    int lat, n1, n2;
    int exp_p [4] = '{8, 4, 2, 16};
    for (int p = 0; p < 4; p++) begin
      tick(10);
      press(0, lat);
      wait_step(n1);
      wait_step(n2);
      n_chk++;
      if (lat !== PRESS_LAT || speed !== 2'((p + 1) % 4) || n1 !== exp_p[p] || n2 !== exp_p[p]) begin
        n_fail++;
        $display("FAIL speed_press_%0d: got lat=%0d speed=%0d gaps=%0d,%0d, want lat=%0d speed=%0d gaps=%0d",
                 p, lat, speed, n1, n2, PRESS_LAT, (p + 1) % 4, exp_p[p]);
      end
    end
  endtask

  task automatic test_pause;
    int n, lat, moved;
    for (int i = 0; i < 10; i++) begin
      wait_step(n);
      if (sw == 3'd3) break;
    end
    press(2, lat);
    n_chk++;
    if (running !== 1'b0 || sw !== 3'd3) begin
      n_fail++;
      $display("FAIL pause_enter: got run=%0d sw=%0d, want run=0 sw=3", running, sw);
    end
    moved = 0;
    repeat (40) begin
      @(negedge clk);
      if (step || sw != 3'd3) moved++;
    end
    n_chk++;
    if (moved !== 0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d moving cycles run=%0d, want 0 run=0", moved, running);
    end
    press(2, lat);
    wait_step(n);
    n_chk++;
    if (running !== 1'b1 || n !== 16 || sw !== 3'd2) begin
      n_fail++;
      $display("FAIL pause_resume: got run=%0d gap=%0d sw=%0d, want run=1 gap=16 sw=2",
               running, n, sw);
    end
  endtask

  task automatic test_reset_mid_run;
    int n, lat;
    press(0, lat); tick(10);
    press(0, lat); tick(10);
    for (int i = 0; i < 10; i++) begin
      wait_step(n);
      if (sw == 3'd5) break;
    end
    n_chk++;
    if (sw !== 3'd5 || speed !== 2'd2 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_setup: got sw=%0d speed=%0d dir=%0d, want 5/2/1", sw, speed, dir);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({sw, step, speed, dir, running} !== 8'b000_0_00_0_1) begin
      n_fail++;
      $display("FAIL async_reset: got sw=%0d step=%0d speed=%0d dir=%0d run=%0d, want 0/0/0/0/1",
               sw, step, speed, dir, running);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_step(n);
    n_chk++;
    if (n !== 16 || sw !== 3'd1 || speed !== 2'd0 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got gap=%0d sw=%0d speed=%0d dir=%0d, want 16/1/0/0",
               n, sw, speed, dir);
    end
  endtask

  task automatic test_event_on_terminal;
    int n;
    logic [2:0] s0;
    wait_step(n);
    s0 = sw;
    tick(16 - PRESS_LAT);
    key_dir = 1'b0; key_speed = 1'b0;
    tick(PRESS_LAT);
    n_chk++;
    if (step !== 1'b1 || sw !== 3'(s0 + 3'd1) || dir !== 1'b1 || speed !== 2'd1) begin
      n_fail++;
      $display("FAIL term_collide: got step=%0d sw=%0d dir=%0d speed=%0d, want 1/%0d/1/1",
               step, sw, dir, speed, 3'(s0 + 3'd1));
    end
    key_dir = 1'b1; key_speed = 1'b1;
    wait_step(n);
    n_chk++;
    if (n !== 8 || sw !== s0) begin
      n_fail++;
      $display("FAIL term_new_period: got gap=%0d sw=%0d, want gap=8 sw=%0d", n, sw, s0);
    end
  endtask

  initial begin
    test_reset();
    test_dir_bounce();
    test_speed();
    test_pause();
    test_reset_mid_run();
    test_event_on_terminal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
